// File: rtl/i2si_bist_wavegen.sv
// I2S-input BIST waveform generator: one test sample per frame.
// Modes are sawtooth, triangle, square and constant; ramps saturate at the limits.
module i2si_bist_wavegen #(
   parameter int DW         = 16,
   parameter int CFG_W      = 12,
   parameter int INC_W      = 8,
   parameter int FRAME_BITS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck_transition,
   input  logic              rf_bist_en,
   input  logic [1:0]        rf_bist_mode,
   input  logic [CFG_W-1:0]  rf_bist_start_val,
   input  logic [CFG_W-1:0]  rf_bist_up_limit,
   input  logic [INC_W-1:0]  rf_bist_inc,
   output logic [2*DW-1:0]   i2si_bist_out_data,
   output logic              i2si_bist_out_xfc
);

   localparam int FCW = $clog2(FRAME_BITS);
   localparam logic [FCW-1:0] LAST = FCW'(FRAME_BITS - 1);
   localparam logic [FCW-1:0] ONE  = FCW'(1);

   localparam logic [1:0] M_SAW = 2'b00;
   localparam logic [1:0] M_TRI = 2'b01;
   localparam logic [1:0] M_SQR = 2'b10;

   typedef enum logic [1:0] {IDLE, UP, DOWN, HI} state_t;

   state_t                state;
   logic [FCW-1:0]        frame_cnt;
   logic                  active;
   logic [1:0]            mode_q;
   logic signed [DW-1:0]  s_q;

   logic                  bnd;
   logic signed [DW-1:0]  st, lim, sc, up_v, dn_v;
   logic signed [DW:0]    inc_x, sum, dif;

   assign bnd = sck_transition && (frame_cnt == LAST);

   assign st    = {{(DW-CFG_W){rf_bist_start_val[CFG_W-1]}}, rf_bist_start_val};
   assign lim   = {{(DW-CFG_W){rf_bist_up_limit[CFG_W-1]}}, rf_bist_up_limit};
   assign inc_x = {{(DW+1-INC_W){1'b0}}, rf_bist_inc};

   // Pull S back into [ST, LIM] so limit changes take effect without a restart
   assign sc = (s_q < st) ? st : ((s_q > lim) ? lim : s_q);

   // One extra bit so the step can never wrap past a limit
   assign sum  = {sc[DW-1], sc} + inc_x;
   assign dif  = {sc[DW-1], sc} - inc_x;
   assign up_v = (sum > {lim[DW-1], lim}) ? lim : sum[DW-1:0];
   assign dn_v = (dif < {st[DW-1], st}) ? st : dif[DW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= LAST;
         active    <= 1'b0;
         state     <= IDLE;
         mode_q    <= M_SAW;
         s_q       <= '0;
      end else begin
         if (sck_transition)
            frame_cnt <= frame_cnt + ONE;
         if (bnd) begin
            active <= rf_bist_en;
            if (!rf_bist_en) begin
               state  <= IDLE;
               mode_q <= M_SAW;
               s_q    <= '0;
            end else if (state == IDLE || rf_bist_mode != mode_q
                         || lim <= st) begin
               state  <= UP;
               mode_q <= rf_bist_mode;
               s_q    <= st;
            end else begin
               unique case (mode_q)
                  M_SAW: begin
                     state <= UP;
                     s_q   <= (sc >= lim) ? st : up_v;
                  end
                  M_TRI: begin
                     if (state == DOWN) begin
                        if (sc <= st) begin
                           s_q   <= up_v;
                           state <= UP;
                        end else begin
                           s_q <= dn_v;
                        end
                     end else begin
                        if (sc >= lim) begin
                           s_q   <= dn_v;
                           state <= DOWN;
                        end else begin
                           s_q   <= up_v;
                           state <= UP;
                        end
                     end
                  end
                  M_SQR: begin
                     if (state == HI) begin
                        s_q   <= st;
                        state <= UP;
                     end else begin
                        s_q   <= lim;
                        state <= HI;
                     end
                  end
                  default: begin
                     s_q   <= st;
                     state <= UP;
                  end
               endcase
            end
         end
      end
   end

   assign i2si_bist_out_data = {~s_q, s_q};
   assign i2si_bist_out_xfc  = active && bnd && !rst;

endmodule

// File: tb/tb_i2si_bist_wavegen.sv
// Scoreboard bench for i2si_bist_wavegen: expected samples are queued by
// the stimulus and popped by a monitor on every transfer-complete pulse.
module tb_i2si_bist_wavegen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck_transition = 1'b0;
   logic        rf_bist_en = 1'b0;
   logic [1:0]  rf_bist_mode = 2'b00;
   logic [11:0] rf_bist_start_val = '0;
   logic [11:0] rf_bist_up_limit = '0;
   logic [7:0]  rf_bist_inc = '0;
   logic [31:0] i2si_bist_out_data;
   logic        i2si_bist_out_xfc;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   i2si_bist_wavegen dut (
      .clk               (clk),
      .rst               (rst),
      .sck_transition    (sck_transition),
      .rf_bist_en        (rf_bist_en),
      .rf_bist_mode      (rf_bist_mode),
      .rf_bist_start_val (rf_bist_start_val),
      .rf_bist_up_limit  (rf_bist_up_limit),
      .rf_bist_inc       (rf_bist_inc),
      .i2si_bist_out_data(i2si_bist_out_data),
      .i2si_bist_out_xfc (i2si_bist_out_xfc)
   );

   always #5 clk = ~clk;

   // Monitor: every xfc must match the oldest queued sample
   initial begin
      forever begin
         @(negedge clk);
         if (i2si_bist_out_xfc) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL xfc_unexpected: got xfc data %h, required no xfc",
                        i2si_bist_out_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (i2si_bist_out_data !== e) begin
                  errors++;
                  $display("FAIL xfc_data: got %h, required %h",
                           i2si_bist_out_data, e);
               end
            end
         end
      end
   end

   task automatic pulse(input int n);
      repeat (n) begin
         @(posedge clk); #1 sck_transition = 1'b1;
         @(posedge clk); #1 sck_transition = 1'b0;
      end
   endtask

   task automatic push(input logic [15:0] v);
      exp_q.push_back({~v, v});
   endtask

   task automatic cfg(input logic [1:0] m, input logic [11:0] s,
                      input logic [11:0] l, input logic [7:0] i);
      rf_bist_mode      = m;
      rf_bist_start_val = s;
      rf_bist_up_limit  = l;
      rf_bist_inc       = i;
   endtask

   task automatic chk_out(input string name, input logic [31:0] d,
                          input logic x);
      checks++;
      if (i2si_bist_out_data !== d || i2si_bist_out_xfc !== x) begin
         errors++;
         $display("FAIL %s: got data %h xfc %b, required data %h xfc %b",
                  name, i2si_bist_out_data, i2si_bist_out_xfc, d, x);
      end
   endtask

   task automatic drain(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d samples outstanding, required 0",
                  name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input string name);
      @(posedge clk); #3 rst = 1'b1;
      #1 chk_out(name, 32'hFFFF_0000, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_out("reset_state", 32'hFFFF_0000, 1'b0);

      // Disabled: no xfc over more than a frame
      pulse(40);
      chk_out("idle_out", 32'hFFFF_0000, 1'b0);
      do_reset("rst_t0");

      // Sawtooth
      cfg(2'b00, 12'h010, 12'h020, 8'd8);
      rf_bist_en = 1'b1;
      push(16'h0010); push(16'h0018); push(16'h0020);
      push(16'h0010); push(16'h0018);
      pulse(1 + 5*32);
      drain("saw_drain");
      do_reset("rst_t1");

      // Saturation at LIM
      cfg(2'b00, 12'h010, 12'h020, 8'h0C);
      push(16'h0010); push(16'h001C); push(16'h0020); push(16'h0010);
      pulse(1 + 4*32);
      drain("sat_drain");
      do_reset("rst_t2");

      // Triangle
      cfg(2'b01, 12'h010, 12'h020, 8'd8);
      push(16'h0010); push(16'h0018); push(16'h0020); push(16'h0018);
      push(16'h0010); push(16'h0018); push(16'h0020);
      pulse(1 + 7*32);
      drain("tri_drain");
      do_reset("rst_t3");

      // Signed square, then switch to constant mid-frame
      cfg(2'b10, 12'hF00, 12'h100, 8'd8);
      push(16'hFF00); push(16'h0100); push(16'hFF00); push(16'h0100);
      pulse(1 + 4*32);
      pulse(10);
      rf_bist_mode = 2'b11;
      push(16'hFF00); push(16'hFF00); push(16'hFF00);
      pulse(22 + 2*32);
      drain("sqr_const_drain");
      do_reset("rst_t4");

      // Degenerate LIM <= ST
      cfg(2'b00, 12'h050, 12'h040, 8'd8);
      push(16'h0050); push(16'h0050); push(16'h0050);
      pulse(1 + 3*32);
      drain("degen_drain");
      do_reset("rst_t5a");

      // inc = 0, saw and triangle hold at ST
      cfg(2'b00, 12'h010, 12'h020, 8'd0);
      push(16'h0010); push(16'h0010); push(16'h0010);
      pulse(1 + 3*32);
      drain("inc0_saw_drain");
      do_reset("rst_t5b");
      cfg(2'b01, 12'h010, 12'h020, 8'd0);
      push(16'h0010); push(16'h0010); push(16'h0010);
      pulse(1 + 3*32);
      drain("inc0_tri_drain");
      do_reset("rst_t5c");

      // Disable: last xfc at the boundary, then silence
      cfg(2'b00, 12'h010, 12'h020, 8'd8);
      push(16'h0010); push(16'h0018);
      pulse(1 + 2*32);
      pulse(5);
      rf_bist_en = 1'b0;
      push(16'h0020);
      pulse(27);
      pulse(2*32);
      chk_out("disabled_out", 32'hFFFF_0000, 1'b0);
      drain("disable_drain");
      do_reset("rst_t6a");

      // Mid-frame reset restarts the frame counter
      rf_bist_en = 1'b1;
      push(16'h0010);
      pulse(1 + 32 + 10);
      drain("pre_rst_drain");
      do_reset("rst_midframe");
      push(16'h0010); push(16'h0018);
      pulse(1 + 2*32);
      drain("post_rst_drain");

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
